// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: host-side control, byte stream and imem write port of the boot loader.
interface imem_boot_loader_if;
   logic        start;
   logic [6:0]  word_count;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        core_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [6:0]  words_loaded;
   modport master (
      output start, word_count, rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wd, core_reset, busy, done, error, words_loaded
   );
   modport slave (
      input  start, word_count, rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wd, core_reset, busy, done, error, words_loaded
   );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads little-endian words from a byte stream into imem, verifies an XOR
// checksum byte and releases the core from reset only after a clean load.
module imem_boot_loader #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic clk,
   input logic reset,
   imem_boot_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
   state_t      state;
   logic [6:0]  cnt;
   logic [1:0]  bidx;
   logic [7:0]  csum;
   logic [23:0] acc;
   logic        xfer;
   logic        bad;
   assign xfer = bus.rx_valid && bus.rx_ready;
   assign bad  = bus.word_count == 7'd0 || {25'd0, bus.word_count} > 32'(DEPTH);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         bidx             <= '0;
         csum             <= '0;
         acc              <= '0;
         bus.rx_ready     <= 1'b0;
         bus.mem_we       <= 1'b0;
         bus.mem_addr     <= BASE_ADDR;
         bus.mem_wd       <= '0;
         bus.core_reset   <= 1'b1;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.error        <= 1'b0;
         bus.words_loaded <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: if (bus.start) begin
               bus.done       <= 1'b0;
               bus.core_reset <= 1'b1;
               if (bad) begin
                  state     <= ERROR;
                  bus.error <= 1'b1;
               end else begin
                  state            <= LOAD;
                  cnt              <= bus.word_count;
                  csum             <= '0;
                  bidx             <= '0;
                  bus.words_loaded <= '0;
                  bus.mem_addr     <= BASE_ADDR;
                  bus.rx_ready     <= 1'b1;
                  bus.busy         <= 1'b1;
                  bus.error        <= 1'b0;
               end
            end
            LOAD: if (xfer) begin
               csum <= csum ^ bus.rx_data;
               bidx <= bidx + 2'd1;
               if (bidx == 2'd3) begin
                  // the write becomes visible the cycle after the 4th byte, with the pre-increment address
                  bus.mem_we       <= 1'b1;
                  bus.mem_wd       <= {bus.rx_data, acc};
                  bus.mem_addr     <= BASE_ADDR + {23'd0, bus.words_loaded, 2'b00};
                  bus.words_loaded <= bus.words_loaded + 7'd1;
                  if (bus.words_loaded + 7'd1 == cnt) state <= CHECK;
               end else begin
                  acc[{bidx, 3'b000} +: 8] <= bus.rx_data;
               end
            end
            CHECK: if (xfer) begin
               bus.rx_ready <= 1'b0;
               bus.busy     <= 1'b0;
               if (bus.rx_data == csum) begin
                  state          <= DONE;
                  bus.done       <= 1'b1;
                  bus.core_reset <= 1'b0;
               end else begin
                  state     <= ERROR;
                  bus.error <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
